// File: rtl/mcontrol_pkg.sv
// Shared definitions for the multi-cycle MIPS main control unit: opcodes,
// state encodings, control-field encodings and the opcode classifier.
package mcontrol_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      FETCH   = 4'd1,
      DECODE  = 4'd2,
      MEMADR  = 4'd3,
      MEMRD   = 4'd4,
      MEMWB   = 4'd5,
      MEMWR   = 4'd6,
      EXEC    = 4'd7,
      RWB     = 4'd8,
      BRANCH  = 4'd9,
      JUMP    = 4'd10,
      ADDI_EX = 4'd11,
      ADDI_WB = 4'd12,
      HALT    = 4'd13
   } mcState_e;

   typedef enum logic [2:0] {
      CLS_NONE    = 3'd0,
      CLS_R       = 3'd1,
      CLS_LW      = 3'd2,
      CLS_SW      = 3'd3,
      CLS_BEQ     = 3'd4,
      CLS_J       = 3'd5,
      CLS_ADDI    = 3'd6,
      CLS_ILLEGAL = 3'd7
   } opClass_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluOp_e;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10
   } pcSrc_e;

   typedef enum logic [1:0] {
      SRCB_B       = 2'b00,
      SRCB_FOUR    = 2'b01,
      SRCB_SEXT    = 2'b10,
      SRCB_SEXT_SH = 2'b11
   } srcB_e;

   typedef struct packed {
      logic   pcWrite;
      logic   pcWriteCond;
      logic   iorD;
      logic   memRead;
      logic   memWrite;
      logic   memToReg;
      logic   irWrite;
      logic   aluSrcA;
      logic   regWrite;
      logic   regDst;
      pcSrc_e pcSource;
      aluOp_e aluOp;
      srcB_e  aluSrcB;
   } ctrlWord_t;

   // Maps a raw opcode to its instruction class; addi can be disabled.
   function automatic opClass_e classifyOp(input logic [5:0] op, input logic addiEn);
      opClass_e cls;
      case (op)
         OP_RTYPE: cls = CLS_R;
         OP_LW:    cls = CLS_LW;
         OP_SW:    cls = CLS_SW;
         OP_BEQ:   cls = CLS_BEQ;
         OP_J:     cls = CLS_J;
         OP_ADDI:  cls = addiEn ? CLS_ADDI : CLS_ILLEGAL;
         default:  cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/mcontrol_fsm_if.sv
// Bundle between the main control unit and the multi-cycle datapath:
// opcode and memory handshake in, datapath controls and status out.
interface mcontrol_fsm_if;
   logic [5:0] Op;
   logic       mem_ready;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       MemtoReg;
   logic       IRWrite;
   logic       ALUSrcA;
   logic       RegWrite;
   logic       RegDst;
   logic [1:0] PCSource;
   logic [1:0] ALUOp;
   logic [1:0] ALUSrcB;
   logic [3:0] state;
   logic       instr_done;
   logic       illegal;

   modport master (
      input  Op, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
             ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB,
             state, instr_done, illegal
   );

   modport slave (
      output Op, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
             ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB,
             state, instr_done, illegal
   );
endinterface

// File: rtl/mcontrol_fsm_decode.sv
// Pure combinational mapping from the current control state (and the
// effective memory-ready) to the datapath control word.
module mcontrol_fsm_decode
   import mcontrol_pkg::*;
(
   input  mcState_e  state,
   input  logic      rdy,
   output ctrlWord_t ctrl
);

   // Every field defaults to 0; each state only raises what it needs.
   // IRWrite/PCWrite in FETCH are gated by rdy so a stalled fetch never commits.
   always_comb begin
      ctrl = '0;
      case (state)
         FETCH: begin
            ctrl.memRead = 1'b1;
            ctrl.aluSrcB = SRCB_FOUR;
            ctrl.irWrite = rdy;
            ctrl.pcWrite = rdy;
         end
         DECODE: ctrl.aluSrcB = SRCB_SEXT_SH;
         MEMADR, ADDI_EX: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = SRCB_SEXT;
         end
         MEMRD: begin
            ctrl.memRead = 1'b1;
            ctrl.iorD    = 1'b1;
         end
         MEMWB: begin
            ctrl.regWrite = 1'b1;
            ctrl.memToReg = 1'b1;
         end
         MEMWR: begin
            ctrl.memWrite = 1'b1;
            ctrl.iorD     = 1'b1;
         end
         EXEC: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluOp   = ALUOP_FUNCT;
         end
         RWB: begin
            ctrl.regDst   = 1'b1;
            ctrl.regWrite = 1'b1;
         end
         BRANCH: begin
            ctrl.aluSrcA     = 1'b1;
            ctrl.aluOp       = ALUOP_SUB;
            ctrl.pcWriteCond = 1'b1;
            ctrl.pcSource    = PCSRC_ALUOUT;
         end
         JUMP: begin
            ctrl.pcWrite  = 1'b1;
            ctrl.pcSource = PCSRC_JUMP;
         end
         ADDI_WB: ctrl.regWrite = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/mcontrol_fsm.sv
// Multi-cycle MIPS main control unit. Holds the state register, the latched
// instruction class and the sticky illegal flag; the control word itself is
// produced by mcontrol_fsm_decode.
module mcontrol_fsm
   import mcontrol_pkg::*;
#(
   parameter bit MEM_WAIT     = 1'b1,
   parameter bit TRAP_ILLEGAL = 1'b1,
   parameter bit ENABLE_ADDI  = 1'b1
)(
   input  logic          clk,
   input  logic          rst_n,
   mcontrol_fsm_if.master bus
);

   mcState_e  state;
   mcState_e  nextState;
   opClass_e  opClass;
   opClass_e  decodedClass;
   logic      illegalFlag;
   logic      rdy;
   ctrlWord_t ctrl;

   assign rdy = MEM_WAIT ? bus.mem_ready : 1'b1;

   // Classify the live opcode; only consumed while in DECODE.
   always_comb begin
      decodedClass = classifyOp(bus.Op, ENABLE_ADDI);
   end

   // Next-state selection. Later states steer on the latched class so the
   // opcode bus is free to change after DECODE.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    nextState = FETCH;
         FETCH:   if (rdy) nextState = DECODE;
         DECODE: begin
            case (decodedClass)
               CLS_R:          nextState = EXEC;
               CLS_LW, CLS_SW: nextState = MEMADR;
               CLS_BEQ:        nextState = BRANCH;
               CLS_J:          nextState = JUMP;
               CLS_ADDI:       nextState = ADDI_EX;
               default:        nextState = TRAP_ILLEGAL ? HALT : FETCH;
            endcase
         end
         MEMADR:  nextState = (opClass == CLS_SW) ? MEMWR : MEMRD;
         MEMRD:   if (rdy) nextState = MEMWB;
         MEMWR:   if (rdy) nextState = FETCH;
         EXEC:    nextState = RWB;
         ADDI_EX: nextState = ADDI_WB;
         MEMWB, RWB, ADDI_WB, BRANCH, JUMP: nextState = FETCH;
         HALT:    nextState = HALT;
         default: nextState = IDLE;
      endcase
   end

   // State register, class latch and sticky illegal flag; reset aborts any
   // instruction in flight by dropping straight back to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         opClass     <= CLS_NONE;
         illegalFlag <= 1'b0;
      end else begin
         state <= nextState;
         if (state == DECODE) begin
            opClass <= decodedClass;
            if (decodedClass == CLS_ILLEGAL) illegalFlag <= 1'b1;
         end
      end
   end

   mcontrol_fsm_decode decodeInst (
      .state (state),
      .rdy   (rdy),
      .ctrl  (ctrl)
   );

   assign bus.PCWrite     = ctrl.pcWrite;
   assign bus.PCWriteCond = ctrl.pcWriteCond;
   assign bus.IorD        = ctrl.iorD;
   assign bus.MemRead     = ctrl.memRead;
   assign bus.MemWrite    = ctrl.memWrite;
   assign bus.MemtoReg    = ctrl.memToReg;
   assign bus.IRWrite     = ctrl.irWrite;
   assign bus.ALUSrcA     = ctrl.aluSrcA;
   assign bus.RegWrite    = ctrl.regWrite;
   assign bus.RegDst      = ctrl.regDst;
   assign bus.PCSource    = ctrl.pcSource;
   assign bus.ALUOp       = ctrl.aluOp;
   assign bus.ALUSrcB     = ctrl.aluSrcB;
   assign bus.state       = state;
   assign bus.instr_done  = (nextState == FETCH) && (state != IDLE) && (state != FETCH);
   assign bus.illegal     = illegalFlag;

endmodule
